eth_tx_frame_buffer: RTL and testbench

- Store-and-forward byte FIFO between the frame detector's TX master stream (m_axis_a/b) and the TEMAC TX slave of the same interface.
- Releases a frame to the TEMAC only once it is completely buffered, so the TEMAC never underruns mid-frame.
- Discards frames that are marked bad (tuser on tlast) or that overflow the buffer.
- One instance per interface; exports drop statistics for the AXI register block.

---
 rtl/eth_pkg.sv | 17 +
 rtl/eth_tx_frame_buffer_skid.sv | 46 ++++
 rtl/eth_tx_frame_buffer.sv | 124 ++++++++++++
 tb/tb_eth_tx_frame_buffer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet stream types and constants used by the TX frame buffer.
package eth_pkg;

  localparam int unsigned ETH_MIN_FRAME = 60;
  localparam int unsigned STAT_WIDTH    = 32;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } eth_beat_t;

  typedef enum logic {
    ST_WRITE = 1'b0,
    ST_DROP  = 1'b1
  } wr_state_e;

endpackage

// File: rtl/eth_tx_frame_buffer_skid.sv
// Two-entry output skid between the BRAM read register and m_axis.
// Upstream guarantees it never pushes while both entries are occupied and no pop occurs.
module eth_tx_frame_buffer_skid
  import eth_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  eth_beat_t in_beat,
  input  logic      in_valid,
  output eth_beat_t out_beat,
  output logic      out_valid,
  input  logic      out_ready,
  output logic [1:0] level_c
);

  eth_beat_t spare;
  logic      spare_valid;
  logic      pop;

  assign pop     = out_valid & out_ready;
  assign level_c = 2'(out_valid) + 2'(spare_valid);

  // Output register refills from the spare first so ordering is preserved.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_beat    <= '0;
      out_valid   <= 1'b0;
      spare       <= '0;
      spare_valid <= 1'b0;
    end else if (!out_valid || pop) begin
      if (spare_valid) begin
        out_beat    <= spare;
        out_valid   <= 1'b1;
        spare       <= in_beat;
        spare_valid <= in_valid;
      end else begin
        out_beat  <= in_valid ? in_beat : '0;
        out_valid <= in_valid;
      end
    end else if (in_valid) begin
      spare       <= in_beat;
      spare_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/eth_tx_frame_buffer.sv
// Store-and-forward TX frame FIFO: frames reach the TEMAC only once fully buffered;
// bad-marked and overflowing frames are discarded and counted.
module eth_tx_frame_buffer
  import eth_pkg::*;
#(
  parameter int unsigned C_BUFFER_SIZE = 4096,
  parameter int unsigned C_ADDR_WIDTH  = $clog2(C_BUFFER_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            s_axis_tdata,
  input  logic                  s_axis_tuser,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [7:0]            m_axis_tdata,
  output logic                  m_axis_tuser,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [STAT_WIDTH-1:0] frames_sent,
  output logic [STAT_WIDTH-1:0] frames_bad,
  output logic [STAT_WIDTH-1:0] frames_overflow
);

  localparam int unsigned PW = C_ADDR_WIDTH + 1;

  eth_beat_t     mem [C_BUFFER_SIZE];
  logic [PW-1:0] wr_ptr, commit_ptr, rd_ptr;
  logic [PW-1:0] wr_ptr_d, commit_ptr_d;
  wr_state_e     state, state_d;
  logic          wr_en, bad_inc, ovf_inc;
  logic          full, rd_issue, rd_valid, out_pop;
  eth_beat_t     rd_beat, out_beat;
  logic [1:0]    skid_level;

  assign s_axis_tready = ~rst;
  assign full          = (wr_ptr - rd_ptr) == PW'(C_BUFFER_SIZE);
  assign out_pop       = m_axis_tvalid & m_axis_tready;

  // Issue a read only if the skid is guaranteed room for it one cycle later.
  assign rd_issue = (rd_ptr != commit_ptr) &&
                    ((3'(skid_level) + 3'(rd_valid) - 3'(out_pop)) <= 3'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_WRITE;
    else     state <= state_d;
  end

  // Write-side frame acceptance / discard decisions.
  always_comb begin
    state_d      = state;
    wr_en        = 1'b0;
    bad_inc      = 1'b0;
    ovf_inc      = 1'b0;
    wr_ptr_d     = wr_ptr;
    commit_ptr_d = commit_ptr;
    if (s_axis_tvalid) begin
      unique case (state)
        ST_WRITE: begin
          if (s_axis_tlast && s_axis_tuser) begin
            wr_ptr_d = commit_ptr;
            bad_inc  = 1'b1;
          end else if (full) begin
            wr_ptr_d = commit_ptr;
            ovf_inc  = 1'b1;
            if (!s_axis_tlast) state_d = ST_DROP;
          end else begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr + PW'(1);
            if (s_axis_tlast) commit_ptr_d = wr_ptr + PW'(1);
          end
        end
        ST_DROP: begin
          if (s_axis_tlast) state_d = ST_WRITE;
        end
        default: state_d = ST_WRITE;
      endcase
    end
  end

  // Inferred BRAM with registered read.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[C_ADDR_WIDTH-1:0]] <= eth_beat_t'{data: s_axis_tdata, last: s_axis_tlast};
    if (rd_issue) rd_beat <= mem[rd_ptr[C_ADDR_WIDTH-1:0]];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr          <= '0;
      commit_ptr      <= '0;
      rd_ptr          <= '0;
      rd_valid        <= 1'b0;
      frames_sent     <= '0;
      frames_bad      <= '0;
      frames_overflow <= '0;
    end else begin
      wr_ptr     <= wr_ptr_d;
      commit_ptr <= commit_ptr_d;
      rd_valid   <= rd_issue;
      if (rd_issue)                frames_sent     <= frames_sent;
      if (rd_issue)                rd_ptr          <= rd_ptr + PW'(1);
      if (out_pop && m_axis_tlast) frames_sent     <= frames_sent + STAT_WIDTH'(1);
      if (bad_inc)                 frames_bad      <= frames_bad + STAT_WIDTH'(1);
      if (ovf_inc)                 frames_overflow <= frames_overflow + STAT_WIDTH'(1);
    end
  end

  eth_tx_frame_buffer_skid u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_beat   (rd_beat),
    .in_valid  (rd_valid),
    .out_beat  (out_beat),
    .out_valid (m_axis_tvalid),
    .out_ready (m_axis_tready),
    .level_c   (skid_level)
  );

  assign m_axis_tdata = out_beat.data;
  assign m_axis_tlast = out_beat.last;
  assign m_axis_tuser = 1'b0;

endmodule

// File: tb/tb_eth_tx_frame_buffer.sv
// Scoreboard bench for eth_tx_frame_buffer: a 4096-byte and a 64-byte instance.
module tb_eth_tx_frame_buffer;
  import eth_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] s_tdata = '0;
  logic       s_tuser = 1'b0, s_tlast = 1'b0, s_tvalid = 1'b0;
  logic       sel = 1'b0;

  logic       ready_big = 1'b0, ready_small = 1'b0, lfsr_en = 1'b0;
  logic [7:0] lfsr = 8'hA5;

  logic        s_tready_big, s_tready_small;
  logic [7:0]  m_tdata_big, m_tdata_small;
  logic        m_tuser_big, m_tuser_small, m_tlast_big, m_tlast_small;
  logic        m_tvalid_big, m_tvalid_small, m_tready_big, m_tready_small;
  logic [31:0] sent_big, bad_big, ovf_big, sent_small, bad_small, ovf_small;

  assign m_tready_big   = lfsr_en ? lfsr[0] : ready_big;
  assign m_tready_small = ready_small;

  eth_tx_frame_buffer #(.C_BUFFER_SIZE(4096)) dut_big (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tuser(s_tuser), .s_axis_tlast(s_tlast),
    .s_axis_tvalid(s_tvalid && !sel), .s_axis_tready(s_tready_big),
    .m_axis_tdata(m_tdata_big), .m_axis_tuser(m_tuser_big), .m_axis_tlast(m_tlast_big),
    .m_axis_tvalid(m_tvalid_big), .m_axis_tready(m_tready_big),
    .frames_sent(sent_big), .frames_bad(bad_big), .frames_overflow(ovf_big)
  );

  eth_tx_frame_buffer #(.C_BUFFER_SIZE(64)) dut_small (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tuser(s_tuser), .s_axis_tlast(s_tlast),
    .s_axis_tvalid(s_tvalid && sel), .s_axis_tready(s_tready_small),
    .m_axis_tdata(m_tdata_small), .m_axis_tuser(m_tuser_small), .m_axis_tlast(m_tlast_small),
    .m_axis_tvalid(m_tvalid_small), .m_axis_tready(m_tready_small),
    .frames_sent(sent_small), .frames_bad(bad_small), .frames_overflow(ovf_small)
  );

  int checks = 0;
  int failures = 0;
  eth_beat_t q_big[$];
  eth_beat_t q_small[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Ready pattern for the stalled-stream test.
  always @(posedge clk) begin
    #1;
    lfsr = lfsr[0] ? ((lfsr >> 1) ^ 8'hB8) : (lfsr >> 1);
  end

  // Output monitors: pop expected beats on each handshake, enforce hold while stalled.
  logic      stall_big = 1'b0, stall_small = 1'b0;
  eth_beat_t held_big, held_small, exp_big, exp_small;

  always @(negedge clk) begin
    if (rst) stall_big = 1'b0;
    else begin
      if (stall_big)
        check("hold_big", 32'({m_tvalid_big, m_tdata_big, m_tlast_big}),
              32'({1'b1, held_big.data, held_big.last}));
      if (m_tvalid_big && m_tready_big) begin
        if (q_big.size() == 0) check("extra_beat_big", 32'd1, 32'd0);
        else begin
          exp_big = q_big.pop_front();
          check("beat_big", 32'({m_tdata_big, m_tlast_big}), 32'({exp_big.data, exp_big.last}));
        end
      end
      stall_big = m_tvalid_big && !m_tready_big;
      held_big  = eth_beat_t'{data: m_tdata_big, last: m_tlast_big};
    end
  end

  always @(negedge clk) begin
    if (rst) stall_small = 1'b0;
    else begin
      if (stall_small)
        check("hold_small", 32'({m_tvalid_small, m_tdata_small, m_tlast_small}),
              32'({1'b1, held_small.data, held_small.last}));
      if (m_tvalid_small && m_tready_small) begin
        if (q_small.size() == 0) check("extra_beat_small", 32'd1, 32'd0);
        else begin
          exp_small = q_small.pop_front();
          check("beat_small", 32'({m_tdata_small, m_tlast_small}), 32'({exp_small.data, exp_small.last}));
        end
      end
      stall_small = m_tvalid_small && !m_tready_small;
      held_small  = eth_beat_t'{data: m_tdata_small, last: m_tlast_small};
    end
  end

  // Called at posedge+1; each beat is accepted at the following posedge.
  task automatic send_frame(input logic to_small, input int len, input logic [7:0] base,
                            input logic bad, input logic term, input logic expect_out);
    eth_beat_t b;
    sel = to_small;
    for (int i = 0; i < len; i++) begin
      s_tdata  = 8'(base + 8'(i));
      s_tlast  = term && (i == len - 1);
      s_tuser  = bad && (i == len - 1);
      s_tvalid = 1'b1;
      if (expect_out) begin
        b = eth_beat_t'{data: s_tdata, last: s_tlast};
        if (to_small) q_small.push_back(b);
        else          q_big.push_back(b);
      end
      @(posedge clk); #1;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tuser  = 1'b0;
  endtask

  task automatic wait_drain(input logic on_small, input string name, input int budget);
    int n = 0;
    while (n < budget && (on_small ? (q_small.size() != 0 || m_tvalid_small)
                                   : (q_big.size() != 0 || m_tvalid_big))) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, 32'(n >= budget), 32'd0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    q_big.delete();
    q_small.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  int  streak;

  initial begin
    // Reset state
    #1;
    check("rst_tready_big", 32'(s_tready_big), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("tready_after_rst", 32'(s_tready_big), 32'd1);
    check("rst_tvalid", 32'(m_tvalid_big), 32'd0);
    check("rst_tdata", 32'(m_tdata_big), 32'd0);
    check("rst_counters", sent_big | bad_big | ovf_big, 32'd0);
    @(posedge clk); #1;

    // 1: single 64-byte frame, latency and continuous stream
    ready_big = 1'b1;
    send_frame(1'b0, 64, 8'h00, 1'b0, 1'b1, 1'b1);
    @(posedge clk); #1;
    check("t1_lat_n1_valid", 32'(m_tvalid_big), 32'd0);
    @(posedge clk); #1;
    check("t1_lat_n2_valid", 32'(m_tvalid_big), 32'd1);
    check("t1_first_data", 32'(m_tdata_big), 32'h00);
    streak = 0;
    for (int k = 0; k < 64; k++) begin
      if (m_tvalid_big) streak++;
      @(posedge clk); #1;
    end
    check("t1_streak", 32'(streak), 32'd64);
    check("t1_frames_sent", sent_big, 32'd1);
    check("t1_tuser", 32'(m_tuser_big), 32'd0);

    // 2: bad frame discarded, good frame passes
    pulse_reset();
    send_frame(1'b0, 64, 8'h40, 1'b1, 1'b1, 1'b0);
    send_frame(1'b0, 60, 8'hC0, 1'b0, 1'b1, 1'b1);
    wait_drain(1'b0, "t2_drain", 500);
    check("t2_frames_bad", bad_big, 32'd1);
    check("t2_frames_sent", sent_big, 32'd1);

    // 3: 64-byte buffer, stalled output, second 40-byte frame overflows
    pulse_reset();
    ready_small = 1'b0;
    send_frame(1'b1, 40, 8'h00, 1'b0, 1'b1, 1'b1);
    send_frame(1'b1, 40, 8'h80, 1'b0, 1'b1, 1'b0);
    repeat (5) begin @(posedge clk); #1; end
    check("t3_overflow", ovf_small, 32'd1);
    check("t3_sent_stalled", sent_small, 32'd0);
    ready_small = 1'b1;
    wait_drain(1'b1, "t3_drain", 500);
    check("t3_frames_sent", sent_small, 32'd1);
    check("t3_bad", bad_small, 32'd0);

    // 4: three back-to-back frames with LFSR-driven tready
    pulse_reset();
    lfsr_en = 1'b1;
    send_frame(1'b0, 60, 8'h10, 1'b0, 1'b1, 1'b1);
    send_frame(1'b0, 60, 8'h50, 1'b0, 1'b1, 1'b1);
    send_frame(1'b0, 60, 8'h90, 1'b0, 1'b1, 1'b1);
    wait_drain(1'b0, "t4_drain", 2000);
    lfsr_en = 1'b0;
    check("t4_frames_sent", sent_big, 32'd3);

    // 5: frame longer than the buffer overflows, next frame intact
    pulse_reset();
    ready_small = 1'b1;
    send_frame(1'b1, 100, 8'h00, 1'b0, 1'b1, 1'b0);
    send_frame(1'b1, 30, 8'h80, 1'b0, 1'b1, 1'b1);
    wait_drain(1'b1, "t5_drain", 500);
    check("t5_overflow", ovf_small, 32'd1);
    check("t5_frames_sent", sent_small, 32'd1);

    // 6: reset mid-frame while output is presenting data
    pulse_reset();
    ready_big = 1'b0;
    send_frame(1'b0, 30, 8'h20, 1'b0, 1'b1, 1'b0);
    send_frame(1'b0, 20, 8'h60, 1'b0, 1'b0, 1'b0);
    check("t6_valid_before", 32'(m_tvalid_big), 32'd1);
    s_tvalid = 1'b1;
    rst = 1'b1;
    #1;
    check("t6_valid_in_rst", 32'(m_tvalid_big), 32'd0);
    check("t6_data_in_rst", 32'({m_tdata_big, m_tlast_big}), 32'd0);
    check("t6_tready_in_rst", 32'(s_tready_big), 32'd0);
    q_big.delete();
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    rst = 1'b0;
    #1;
    check("t6_counters", sent_big | bad_big | ovf_big, 32'd0);
    ready_big = 1'b1;
    @(posedge clk); #1;
    send_frame(1'b0, 60, 8'hA0, 1'b0, 1'b1, 1'b1);
    wait_drain(1'b0, "t6_drain", 500);
    check("t6_frames_sent", sent_big, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
